// File: rtl/axi_mem_master_pkg.sv
// axi_mem_master_pkg: shared FSM states and AXI encodings for the memory-port AXI master
package axi_mem_master_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WAIT_B       = 3'd2,
        RD_ADDR      = 3'd3,
        WAIT_R       = 3'd4
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_mem_master_if.sv
// axi_mem_master_if: turns single-port SRAM-style requests into single-beat AXI4 transactions
module axi_mem_master_if
    import axi_mem_master_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 64,
    parameter int AXI4_DATA_WIDTH    = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int AXI_NUMBYTES       = AXI4_DATA_WIDTH / 8,
    parameter int AXI_ID_VAL         = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] addr_i,
    input  logic [AXI4_DATA_WIDTH-1:0]    wdata_i,
    input  logic [AXI_NUMBYTES-1:0]       be_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [AXI4_DATA_WIDTH-1:0]    rdata_o,
    output logic                          err_o,
    output logic                          aw_valid,
    output logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr,
    output logic [AXI4_ID_WIDTH-1:0]      aw_id,
    output logic [7:0]                    aw_len,
    output logic [2:0]                    aw_size,
    output logic [1:0]                    aw_burst,
    output logic                          aw_lock,
    output logic [3:0]                    aw_cache,
    output logic [2:0]                    aw_prot,
    output logic [3:0]                    aw_region,
    output logic [3:0]                    aw_qos,
    output logic [AXI4_USER_WIDTH-1:0]    aw_user,
    input  logic                          aw_ready,
    output logic                          w_valid,
    output logic [AXI4_DATA_WIDTH-1:0]    w_data,
    output logic [AXI_NUMBYTES-1:0]       w_strb,
    output logic                          w_last,
    output logic [AXI4_USER_WIDTH-1:0]    w_user,
    input  logic                          w_ready,
    input  logic                          b_valid,
    input  logic [1:0]                    b_resp,
    input  logic [AXI4_ID_WIDTH-1:0]      b_id,
    output logic                          b_ready,
    output logic                          ar_valid,
    output logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr,
    output logic [AXI4_ID_WIDTH-1:0]      ar_id,
    output logic [7:0]                    ar_len,
    output logic [2:0]                    ar_size,
    output logic [1:0]                    ar_burst,
    output logic                          ar_lock,
    output logic [3:0]                    ar_cache,
    output logic [2:0]                    ar_prot,
    output logic [3:0]                    ar_region,
    output logic [3:0]                    ar_qos,
    output logic [AXI4_USER_WIDTH-1:0]    ar_user,
    input  logic                          ar_ready,
    input  logic                          r_valid,
    input  logic [AXI4_DATA_WIDTH-1:0]    r_data,
    input  logic [1:0]                    r_resp,
    input  logic                          r_last,
    input  logic [AXI4_ID_WIDTH-1:0]      r_id,
    output logic                          r_ready
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_NUMBYTES));

    state_t                          state;
    logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q;
    logic [AXI4_DATA_WIDTH-1:0]      wdata_q;
    logic [AXI_NUMBYTES-1:0]         be_q;
    logic [AXI4_DATA_WIDTH-1:0]      rdata_q;
    logic                            aw_done;
    logic                            w_done;
    logic                            rvalid_q;
    logic                            err_q;
    logic                            aw_hs;
    logic                            w_hs;
    logic                            unused;

    // IDs are never checked since only one transaction is ever in flight
    assign unused = ^{b_id, r_id, b_resp[0], r_resp[0]};

    assign gnt_o    = (state == IDLE) && req_i;
    assign aw_valid = (state == WR_ADDR_DATA) && !aw_done;
    assign w_valid  = (state == WR_ADDR_DATA) && !w_done;
    assign b_ready  = (state == WAIT_B);
    assign ar_valid = (state == RD_ADDR);
    assign r_ready  = (state == WAIT_R);
    assign aw_hs    = aw_valid && aw_ready;
    assign w_hs     = w_valid && w_ready;

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = rvalid_q && err_q;

    assign aw_addr   = addr_q;
    assign aw_id     = AXI4_ID_WIDTH'(AXI_ID_VAL);
    assign aw_len    = 8'd0;
    assign aw_size   = AXI_SIZE;
    assign aw_burst  = BURST_INCR;
    assign aw_lock   = 1'b0;
    assign aw_cache  = 4'd0;
    assign aw_prot   = 3'd0;
    assign aw_region = 4'd0;
    assign aw_qos    = 4'd0;
    assign aw_user   = '0;
    assign w_data    = wdata_q;
    assign w_strb    = be_q;
    assign w_last    = 1'b1;
    assign w_user    = '0;
    assign ar_addr   = addr_q;
    assign ar_id     = AXI4_ID_WIDTH'(AXI_ID_VAL);
    assign ar_len    = 8'd0;
    assign ar_size   = AXI_SIZE;
    assign ar_burst  = BURST_INCR;
    assign ar_lock   = 1'b0;
    assign ar_cache  = 4'd0;
    assign ar_prot   = 3'd0;
    assign ar_region = 4'd0;
    assign ar_qos    = 4'd0;
    assign ar_user   = '0;

    // Latch the request on grant so the AXI side sees stable address/data
    always_ff @(posedge clk_i) begin
        if (gnt_o) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
        end
    end

    // Transaction FSM; AW and W are tracked separately so they may finish in any order
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            case (state)
                IDLE: if (req_i) state <= we_i ? WR_ADDR_DATA : RD_ADDR;
                WR_ADDR_DATA: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state   <= WAIT_B;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done || aw_hs;
                        w_done  <= w_done || w_hs;
                    end
                end
                WAIT_B: if (b_valid) begin
                    state    <= IDLE;
                    rvalid_q <= 1'b1;
                    err_q    <= b_resp[1];
                end
                RD_ADDR: if (ar_ready) state <= WAIT_R;
                WAIT_R: if (r_valid) begin
                    state    <= IDLE;
                    rvalid_q <= 1'b1;
                    err_q    <= r_resp[1];
                    rdata_q  <= r_data;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-beat reads must always carry r_last
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == WAIT_R && r_valid) assert (r_last);
    end

endmodule

// File: tb/tb_axi_mem_master_if.sv
// tb_axi_mem_master_if: directed scenario checks of the memory-port AXI master
module tb_axi_mem_master_if;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [63:0] addr, wdata;
    logic [7:0]  be;
    logic        gnt, rvalid, err;
    logic [63:0] rdata;
    logic        aw_valid, aw_lock, aw_ready;
    logic [63:0] aw_addr;
    logic [15:0] aw_id;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size, aw_prot;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_cache, aw_region, aw_qos;
    logic [9:0]  aw_user, w_user, ar_user;
    logic        w_valid, w_last, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [15:0] b_id;
    logic        ar_valid, ar_lock, ar_ready;
    logic [63:0] ar_addr;
    logic [15:0] ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size, ar_prot;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_cache, ar_region, ar_qos;
    logic        r_valid, r_last, r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [15:0] r_id;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    axi_mem_master_if dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot),
        .aw_region(aw_region), .aw_qos(aw_qos), .aw_user(aw_user), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
        .w_ready(w_ready), .b_valid(b_valid), .b_resp(b_resp), .b_id(b_id), .b_ready(b_ready),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .ar_region(ar_region), .ar_qos(ar_qos), .ar_user(ar_user), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_id(r_id),
        .r_ready(r_ready)
    );

    task automatic read_txn(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp,
                            input int stall, output logic g, output logic rv, output logic er,
                            output logic [63:0] rd, output int bad);
        bad = 0;
        @(negedge clk); req = 1'b1; we = 1'b0; addr = a;
        #1 g = gnt;
        @(negedge clk); req = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1 if (!(ar_valid === 1'b1 && ar_addr === a && r_ready === 1'b0)) bad++;
            @(negedge clk);
        end
        #1 if (!(ar_valid === 1'b1 && ar_addr === a && r_ready === 1'b0)) bad++;
        ar_ready = 1'b1;
        @(negedge clk); ar_ready = 1'b0;
        #1 if (r_ready !== 1'b1 || ar_valid !== 1'b0) bad++;
        r_valid = 1'b1; r_data = d; r_resp = resp; r_last = 1'b1;
        @(negedge clk); r_valid = 1'b0;
        #1 rv = rvalid; er = err; rd = rdata;
    endtask

    task automatic write_txn(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp,
                             output logic rv, output logic er);
        @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d; be = 8'hFF;
        @(negedge clk); req = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk); aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b1; b_resp = resp;
        @(negedge clk); b_valid = 1'b0;
        #1 rv = rvalid; er = err;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0; b_id = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b1; r_id = '0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt, rvalid, err} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl got %b exp 00000000", {aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt, rvalid, err});
        end
        tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        rst = 1'b0;
    endtask

    task automatic test_read;
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 64'h1000;
        #1 tests++; if (gnt !== 1'b1) begin fails++; $display("FAIL rd_gnt got %b exp 1", gnt); end
        @(negedge clk); req = 1'b0;
        #1 tests++; if (ar_valid !== 1'b1 || ar_addr !== 64'h1000) begin
            fails++; $display("FAIL rd_ar got valid=%b addr=%h exp valid=1 addr=1000", ar_valid, ar_addr);
        end
        tests++; if ({ar_size, ar_len, ar_burst, ar_id} !== {3'd3, 8'd0, 2'b01, 16'd0}) begin
            fails++; $display("FAIL rd_ar_attr got size=%0d len=%0d burst=%b id=%h exp 3 0 01 0", ar_size, ar_len, ar_burst, ar_id);
        end
        tests++; if (r_ready !== 1'b0) begin fails++; $display("FAIL rd_rready_early got %b exp 0", r_ready); end
        ar_ready = 1'b1;
        @(negedge clk); ar_ready = 1'b0;
        #1 tests++; if (r_ready !== 1'b1) begin fails++; $display("FAIL rd_rready got %b exp 1", r_ready); end
        r_valid = 1'b1; r_data = 64'hDEADBEEF_CAFEF00D; r_resp = 2'b00; r_last = 1'b1;
        @(negedge clk); r_valid = 1'b0;
        #1 tests++; if ({rvalid, err} !== 2'b10 || rdata !== 64'hDEADBEEF_CAFEF00D) begin
            fails++; $display("FAIL rd_resp got rvalid=%b err=%b rdata=%h exp 1 0 deadbeefcafef00d", rvalid, err, rdata);
        end
        @(negedge clk);
        #1 tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL rd_pulse got %b exp 0", rvalid); end
    endtask

    task automatic test_write;
        @(negedge clk); req = 1'b1; we = 1'b1; addr = 64'h2008; wdata = 64'h11223344_55667788; be = 8'h0F;
        #1 tests++; if (gnt !== 1'b1) begin fails++; $display("FAIL wr_gnt got %b exp 1", gnt); end
        @(negedge clk); req = 1'b0;
        #1 tests++; if ({aw_valid, w_valid, w_last, w_strb} !== {3'b111, 8'h0F} || w_data !== 64'h11223344_55667788 || aw_addr !== 64'h2008) begin
            fails++; $display("FAIL wr_chan got aw=%b w=%b last=%b strb=%h data=%h addr=%h exp 1 1 1 0f 1122334455667788 2008", aw_valid, w_valid, w_last, w_strb, w_data, aw_addr);
        end
        w_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); w_ready = 1'b0;
            #1 tests++; if ({aw_valid, w_valid, b_ready} !== 3'b100 || aw_addr !== 64'h2008) begin
                fails++; $display("FAIL wr_aw_hold%0d got aw=%b w=%b bready=%b addr=%h exp 1 0 0 2008", i, aw_valid, w_valid, b_ready, aw_addr);
            end
        end
        aw_ready = 1'b1;
        @(negedge clk); aw_ready = 1'b0;
        #1 tests++; if ({aw_valid, w_valid, b_ready, rvalid} !== 4'b0010) begin
            fails++; $display("FAIL wr_waitb got aw=%b w=%b bready=%b rvalid=%b exp 0 0 1 0", aw_valid, w_valid, b_ready, rvalid);
        end
        b_valid = 1'b1; b_resp = 2'b00;
        @(negedge clk); b_valid = 1'b0;
        #1 tests++; if ({rvalid, err} !== 2'b10 || rdata !== 64'hDEADBEEF_CAFEF00D) begin
            fails++; $display("FAIL wr_resp got rvalid=%b err=%b rdata=%h exp 1 0 deadbeefcafef00d", rvalid, err, rdata);
        end
        @(negedge clk);
        #1 tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL wr_pulse got %b exp 0", rvalid); end
    endtask

    task automatic test_error;
        logic g, rv, er;
        logic [63:0] rd;
        int bad;
        read_txn(64'h3000, 64'h55, 2'b10, 0, g, rv, er, rd, bad);
        tests++; if ({g, rv, er} !== 3'b111 || rd !== 64'h55 || bad !== 0) begin
            fails++; $display("FAIL err_rd got gnt=%b rvalid=%b err=%b rdata=%h bad=%0d exp 1 1 1 55 0", g, rv, er, rd, bad);
        end
        write_txn(64'h3008, 64'h77, 2'b11, rv, er);
        tests++; if ({rv, er} !== 2'b11 || rdata !== 64'h55) begin
            fails++; $display("FAIL err_wr got rvalid=%b err=%b rdata=%h exp 1 1 55", rv, er, rdata);
        end
    endtask

    task automatic test_back_to_back;
        int gcnt = 0;
        int busy_g = 0;
        logic rv3, g3;
        @(negedge clk); req = 1'b1; we = 1'b1; addr = 64'h4000; wdata = 64'hA5; be = 8'hFF;
        #1 gcnt += int'(gnt);
        @(negedge clk); we = 1'b0; addr = 64'h5000; aw_ready = 1'b1; w_ready = 1'b1;
        #1 busy_g += int'(gnt);
        @(negedge clk); aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b00;
        #1 busy_g += int'(gnt);
        @(negedge clk); b_valid = 1'b0;
        #1 rv3 = rvalid; g3 = gnt; gcnt += int'(gnt);
        @(negedge clk);
        #1 busy_g += int'(gnt);
        tests++; if (ar_valid !== 1'b1 || ar_addr !== 64'h5000) begin
            fails++; $display("FAIL b2b_ar got valid=%b addr=%h exp 1 5000", ar_valid, ar_addr);
        end
        ar_ready = 1'b1;
        @(negedge clk); ar_ready = 1'b0;
        #1 busy_g += int'(gnt);
        r_valid = 1'b1; r_data = 64'h0123456789ABCDEF; r_resp = 2'b00;
        @(negedge clk); r_valid = 1'b0; req = 1'b0;
        #1 gcnt += int'(gnt);
        tests++; if ({rv3, g3} !== 2'b11) begin fails++; $display("FAIL b2b_overlap got rvalid=%b gnt=%b exp 1 1", rv3, g3); end
        tests++; if (gcnt !== 2) begin fails++; $display("FAIL b2b_gnt_count got %0d exp 2", gcnt); end
        tests++; if (busy_g !== 0) begin fails++; $display("FAIL b2b_busy_gnt got %0d exp 0", busy_g); end
        tests++; if (rvalid !== 1'b1 || rdata !== 64'h0123456789ABCDEF) begin
            fails++; $display("FAIL b2b_rd got rvalid=%b rdata=%h exp 1 0123456789abcdef", rvalid, rdata);
        end
    endtask

    task automatic test_backpressure;
        logic g, rv, er;
        logic [63:0] rd;
        int bad;
        read_txn(64'h6000, 64'hFEED, 2'b00, 5, g, rv, er, rd, bad);
        tests++; if (bad !== 0) begin fails++; $display("FAIL bp_stable got %0d bad cycles exp 0", bad); end
        tests++; if ({g, rv, er} !== 3'b110 || rd !== 64'hFEED) begin
            fails++; $display("FAIL bp_resp got gnt=%b rvalid=%b err=%b rdata=%h exp 1 1 0 feed", g, rv, er, rd);
        end
    endtask

    task automatic test_reset_mid_write;
        logic g, rv, er;
        logic [63:0] rd;
        int bad;
        @(negedge clk); req = 1'b1; we = 1'b1; addr = 64'h7000; wdata = 64'h99; be = 8'hFF;
        @(negedge clk); req = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk); aw_ready = 1'b0; w_ready = 1'b0;
        #1 tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_waitb got %b exp 1", b_ready); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1 tests++; if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt, rvalid} !== 7'b0) begin
            fails++; $display("FAIL rst_mid_ctrl got %b exp 0000000", {aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt, rvalid});
        end
        read_txn(64'h8000, 64'hC0FFEE, 2'b00, 0, g, rv, er, rd, bad);
        tests++; if ({g, rv, er} !== 3'b110 || rd !== 64'hC0FFEE || bad !== 0) begin
            fails++; $display("FAIL rst_mid_read got gnt=%b rvalid=%b err=%b rdata=%h bad=%0d exp 1 1 0 c0ffee 0", g, rv, er, rd, bad);
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_error;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_write;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
